bird_sprite_drawer: RTL and testbench

//  Per-pixel renderer for the bird enemy; consumes the two 32x32 palette-index frames of the bird sprite ROMs.

---
 rtl/bird_sprite_drawer.sv | 157 +++++++++++++++
 tb/tb_bird_sprite_drawer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bird_sprite_drawer.sv
// Two-stage per-pixel renderer for the bird enemy with frame-counted flap animation.
// Optional horizontal mirroring is built when BIRD_MIRROR_EN is defined.
module bird_sprite_drawer #(
  parameter int unsigned SPRITE_W        = 32,
  parameter int unsigned IDX_W           = 10,
  parameter int unsigned ANIM_FRAMES     = 8,
  parameter int unsigned TRANSPARENT_IDX = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_sync,
  input  logic             pix_valid,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic [9:0]       BirdX,
  input  logic [9:0]       BirdY,
  input  logic             bird_alive,
  input  logic             facing_left,
  input  logic [IDX_W-1:0] sprite0 [SPRITE_W][SPRITE_W],
  input  logic [IDX_W-1:0] sprite1 [SPRITE_W][SPRITE_W],
  output logic             bird_on,
  output logic [IDX_W-1:0] bird_idx,
  output logic             pix_valid_o,
  output logic             frame_sel
);

  localparam int unsigned POS_W  = 10;
  localparam int unsigned DIFF_W = POS_W + 1;
  localparam int unsigned SUB_W  = $clog2(SPRITE_W);
  localparam int unsigned CNT_W  = $clog2(ANIM_FRAMES);

  typedef enum logic {HIDDEN, FLAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] anim_cnt;
  logic [POS_W-1:0] sh_x;
  logic [POS_W-1:0] sh_y;
  logic             sh_alive;

  // Position shadows only move at frame_sync so a frame never tears
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sh_x     <= '0;
      sh_y     <= '0;
      sh_alive <= 1'b0;
    end else if (frame_sync) begin
      sh_x     <= BirdX;
      sh_y     <= BirdY;
      sh_alive <= bird_alive;
    end
  end

`ifdef BIRD_MIRROR_EN
  logic sh_facing;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sh_facing <= 1'b0;
    else if (frame_sync) sh_facing <= facing_left;
  end
`else
  logic unused_facing;
  assign unused_facing = facing_left;
`endif

  // Animation FSM; the wake-up pulse counts as the first flap tick
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= HIDDEN;
      anim_cnt  <= '0;
      frame_sel <= 1'b0;
    end else if (frame_sync) begin
      case (state)
        HIDDEN: begin
          anim_cnt  <= '0;
          frame_sel <= 1'b0;
          if (bird_alive) begin
            state    <= FLAP;
            anim_cnt <= CNT_W'(1);
          end
        end
        FLAP: begin
          if (!bird_alive) begin
            state     <= HIDDEN;
            anim_cnt  <= '0;
            frame_sel <= 1'b0;
          end else if (anim_cnt == CNT_W'(ANIM_FRAMES - 1)) begin
            anim_cnt  <= '0;
            frame_sel <= ~frame_sel;
          end else begin
            anim_cnt <= anim_cnt + CNT_W'(1);
          end
        end
        default: state <= HIDDEN;
      endcase
    end
  end

  logic [DIFF_W-1:0] dx_c;
  logic [DIFF_W-1:0] dy_c;
  logic              hit_c;
  logic [SUB_W-1:0]  col_c;

  // Negative offsets wrap to large unsigned values, so one compare clips all edges
  always_comb begin
    dx_c  = {1'b0, DrawX} - {1'b0, sh_x};
    dy_c  = {1'b0, DrawY} - {1'b0, sh_y};
    hit_c = pix_valid && (state == FLAP) && sh_alive &&
            (dx_c < DIFF_W'(SPRITE_W)) && (dy_c < DIFF_W'(SPRITE_W));
    col_c = dx_c[SUB_W-1:0];
`ifdef BIRD_MIRROR_EN
    if (sh_facing) col_c = SUB_W'(SPRITE_W - 1) - dx_c[SUB_W-1:0];
`endif
  end

  logic             hit_s1;
  logic             valid_s1;
  logic             fsel_s1;
  logic [SUB_W-1:0] row_s1;
  logic [SUB_W-1:0] col_s1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_s1   <= 1'b0;
      valid_s1 <= 1'b0;
      fsel_s1  <= 1'b0;
      row_s1   <= '0;
      col_s1   <= '0;
    end else begin
      hit_s1   <= hit_c;
      valid_s1 <= pix_valid;
      fsel_s1  <= frame_sel;
      row_s1   <= dy_c[SUB_W-1:0];
      col_s1   <= col_c;
    end
  end

  logic [IDX_W-1:0] idx_c;
  logic             opaque_c;

  always_comb begin
    idx_c    = fsel_s1 ? sprite1[row_s1][col_s1] : sprite0[row_s1][col_s1];
    opaque_c = hit_s1 && (idx_c != IDX_W'(TRANSPARENT_IDX));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bird_on     <= 1'b0;
      bird_idx    <= '0;
      pix_valid_o <= 1'b0;
    end else begin
      bird_on     <= opaque_c;
      bird_idx    <= opaque_c ? idx_c : '0;
      pix_valid_o <= valid_s1;
    end
  end

endmodule

// File: tb/tb_bird_sprite_drawer.sv
// Directed self-checking bench for bird_sprite_drawer.
// Mirror case is exercised only when BIRD_MIRROR_EN is defined.
module tb_bird_sprite_drawer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_sync;
  logic       pix_valid;
  logic [9:0] DrawX, DrawY, BirdX, BirdY;
  logic       bird_alive;
  logic       facing_left;
  logic [9:0] sprite0 [32][32];
  logic [9:0] sprite1 [32][32];
  logic       bird_on;
  logic [9:0] bird_idx;
  logic       pix_valid_o;
  logic       frame_sel;

  int n_checks = 0;
  int n_pass   = 0;

  bird_sprite_drawer dut (
    .Clk(Clk), .Reset(Reset), .frame_sync(frame_sync), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .BirdX(BirdX), .BirdY(BirdY),
    .bird_alive(bird_alive), .facing_left(facing_left),
    .sprite0(sprite0), .sprite1(sprite1),
    .bird_on(bird_on), .bird_idx(bird_idx), .pix_valid_o(pix_valid_o),
    .frame_sel(frame_sel)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Frame A: column 5 transparent; frame B: only [0][0] transparent, [0][24]=254, [31][31]=229
  function automatic logic [9:0] rom0(input int r, input int c);
    if (c == 5) return 10'd0;
    return 10'(r * 7 + c * 3 + 1);
  endfunction

  function automatic logic [9:0] rom1(input int r, input int c);
    if (r == 0 && c == 0) return 10'd0;
    return 10'(r * 32 + c + 230);
  endfunction

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame_sync = 1'b1;
      @(posedge Clk); #1;
      frame_sync = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input int exp_on, input int exp_idx);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
    @(posedge Clk); #1;
    pix_valid = 1'b0;
    @(posedge Clk); #1;
    check({tag, ".on"}, int'(bird_on), exp_on);
    check({tag, ".idx"}, int'(bird_idx), exp_idx);
    check({tag, ".vld"}, int'(pix_valid_o), 1);
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        sprite0[r][c] = rom0(r, c);
        sprite1[r][c] = rom1(r, c);
      end
    Reset = 1'b1; frame_sync = 1'b0; pix_valid = 1'b0;
    DrawX = '0; DrawY = '0; BirdX = 10'd100; BirdY = 10'd50;
    bird_alive = 1'b1; facing_left = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst.on", int'(bird_on), 0);
    check("rst.idx", int'(bird_idx), 0);
    check("rst.vld", int'(pix_valid_o), 0);
    check("rst.fsel", int'(frame_sel), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Animation start: toggle on the 8th pulse
    pulse(7);
    check("anim7.fsel", int'(frame_sel), 0);
    pulse(1);
    check("anim8.fsel", int'(frame_sel), 1);
    pix("hitB", 124, 50, 1, 254);
    pix("transB", 100, 50, 0, 0);

    // Clipping around bird at (100,50)
    pix("clipL", 99, 50, 0, 0);
    pix("clipR", 132, 50, 0, 0);
    pix("clipB", 110, 82, 0, 0);
    pix("cornerB", 131, 81, 1, 229);

    // Tear guard: BirdX moves mid-frame, shadows hold until frame_sync
    BirdX = 10'd200;
    pix("tear.old", 124, 50, 1, 254);
    pix("tear.new", 224, 50, 0, 0);
    DrawX = 10'd124; DrawY = 10'd50; pix_valid = 1'b1; frame_sync = 1'b1;
    @(posedge Clk); #1;
    pix_valid = 1'b0; frame_sync = 1'b0;
    @(posedge Clk); #1;
    check("tear.sync.on", int'(bird_on), 1);
    check("tear.sync.idx", int'(bird_idx), 254);
    pix("tear.after", 224, 50, 1, 254);
    pix("tear.gone", 124, 50, 0, 0);

    // Pulses 10..16 with bird at origin; 16th toggles back to frame A
    BirdX = 10'd0; BirdY = 10'd0;
    pulse(6);
    check("anim15.fsel", int'(frame_sel), 1);
    pulse(1);
    check("anim16.fsel", int'(frame_sel), 0);
    pix("cornerA", 31, 31, 1, 311);
    pix("transA", 5, 3, 0, 0);

    // Kill mid-count, then wake: counter must restart from scratch
    pulse(4);
    bird_alive = 1'b0;
    pulse(1);
    check("kill.fsel", int'(frame_sel), 0);
    pix("kill.hidden", 31, 31, 0, 0);
    BirdX = 10'd100; BirdY = 10'd50; bird_alive = 1'b1;
    pulse(7);
    check("wake7.fsel", int'(frame_sel), 0);
    pulse(1);
    check("wake8.fsel", int'(frame_sel), 1);
    bird_alive = 1'b0;
    pulse(1);
    check("kill2.fsel", int'(frame_sel), 0);
    pix("kill2.hidden", 124, 50, 0, 0);
    bird_alive = 1'b1;
    pulse(1);
    pix("wakeA", 101, 50, 1, 4);

    // Mid-line reset with a live opaque pixel stream
    DrawX = 10'd101; DrawY = 10'd50; pix_valid = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    check("live.on", int'(bird_on), 1);
    check("live.idx", int'(bird_idx), 4);
    Reset = 1'b1;
    #1;
    check("midrst.on", int'(bird_on), 0);
    check("midrst.idx", int'(bird_idx), 0);
    check("midrst.vld", int'(pix_valid_o), 0);
    check("midrst.fsel", int'(frame_sel), 0);
    @(negedge Clk);
    Reset = 1'b0; pix_valid = 1'b0;
    @(posedge Clk); #1;
    pix("postrst.hidden", 101, 50, 0, 0);
    pulse(1);
    pix("postrst.wake", 101, 50, 1, 4);

`ifdef BIRD_MIRROR_EN
    facing_left = 1'b1;
    pulse(7);
    check("mirror.fsel", int'(frame_sel), 1);
    pix("mirror", 107, 50, 1, 254);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
